nibble_deserializer: RTL and testbench

Serial-to-parallel front end for the 4-bit register stage: collects a framed serial bit stream into a 4-bit nibble and presents it on a valid/ready output. Its nibble output drives the register stage's data input, and its valid output drives that stage's enable. The output is held stable until the consumer accepts it.

---
 rtl/nibble_deserializer_if.sv | 23 ++
 rtl/nibble_deserializer.sv | 142 ++++++++++++++
 tb/tb_nibble_deserializer.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/nibble_deserializer_if.sv
// Handshake bundle between the serial source, the deserializer and the register stage.
interface nibble_deserializer_if;
   logic       start;
   logic       sin;
   logic       sin_valid;
   logic       out_ready;
   logic [3:0] nib;
   logic       nib_valid;
   logic       busy;
   logic       frame_err;

   // Source/consumer side
   modport master (
      output start, sin, sin_valid, out_ready,
      input  nib, nib_valid, busy, frame_err
   );

   // Deserializer side
   modport slave (
      input  start, sin, sin_valid, out_ready,
      output nib, nib_valid, busy, frame_err
   );
endinterface

// File: rtl/nibble_deserializer.sv
// Framed serial-to-parallel front end producing a 4-bit nibble on valid/ready.
// Optional even-parity check per frame: define NIBBLE_DESER_PARITY_EN.
module nibble_deserializer #(
   parameter bit MSB_FIRST = 1'b1
) (
   input logic                  clk,
   input logic                  rst_n,
   nibble_deserializer_if.slave bus
);

   localparam int unsigned NIB_W = 4;
   localparam int unsigned CNT_W = 2;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RECV = 2'd1,
`ifdef NIBBLE_DESER_PARITY_EN
      PAR  = 2'd2,
`endif
      OUT  = 2'd3
   } state_t;

   state_t             state, state_nxt;
   logic [NIB_W-1:0]   sreg, sreg_nxt, shifted_c;
   logic [CNT_W-1:0]   cnt, cnt_nxt;
   logic [NIB_W-1:0]   nib_q, nib_nxt;
   logic               valid_q, valid_nxt;
   logic               busy_q, busy_nxt;
   logic               err_q, err_nxt;

   // Shift-register input path for the selected bit order
   generate
      if (MSB_FIRST) begin : g_msb
         assign shifted_c = {sreg[NIB_W-2:0], bus.sin};
      end else begin : g_lsb
         assign shifted_c = {bus.sin, sreg[NIB_W-1:1]};
      end
   endgenerate

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   // Next-state, datapath and next-output decode
   always_comb begin
      state_nxt = state;
      sreg_nxt  = sreg;
      cnt_nxt   = cnt;
      err_nxt   = 1'b0;

      case (state)
         IDLE: begin
            if (bus.start) begin
               state_nxt = RECV;
               sreg_nxt  = '0;
               cnt_nxt   = '0;
            end
         end
         RECV: begin
            if (bus.start) begin
               // abort: restart the frame, ignore any same-cycle bit
               err_nxt  = 1'b1;
               sreg_nxt = '0;
               cnt_nxt  = '0;
            end else if (bus.sin_valid) begin
               sreg_nxt = shifted_c;
               cnt_nxt  = cnt + CNT_W'(1);
               if (cnt == CNT_W'(NIB_W - 1)) begin
`ifdef NIBBLE_DESER_PARITY_EN
                  state_nxt = PAR;
`else
                  state_nxt = OUT;
`endif
               end
            end
         end
`ifdef NIBBLE_DESER_PARITY_EN
         PAR: begin
            if (bus.start) begin
               state_nxt = RECV;
               err_nxt   = 1'b1;
               sreg_nxt  = '0;
               cnt_nxt   = '0;
            end else if (bus.sin_valid) begin
               if ((^sreg) ^ bus.sin) begin
                  // odd parity: drop the nibble
                  state_nxt = IDLE;
                  err_nxt   = 1'b1;
                  sreg_nxt  = '0;
                  cnt_nxt   = '0;
               end else begin
                  state_nxt = OUT;
               end
            end
         end
`endif
         OUT: begin
            if (bus.out_ready) begin
               state_nxt = IDLE;
               sreg_nxt  = '0;
               cnt_nxt   = '0;
            end
         end
         default: begin
            state_nxt = IDLE;
            sreg_nxt  = '0;
            cnt_nxt   = '0;
         end
      endcase

      valid_nxt = (state_nxt == OUT);
      nib_nxt   = valid_nxt ? sreg_nxt : '0;
      busy_nxt  = (state_nxt != IDLE);
   end

   // Datapath and output registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sreg    <= '0;
         cnt     <= '0;
         nib_q   <= '0;
         valid_q <= 1'b0;
         busy_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         sreg    <= sreg_nxt;
         cnt     <= cnt_nxt;
         nib_q   <= nib_nxt;
         valid_q <= valid_nxt;
         busy_q  <= busy_nxt;
         err_q   <= err_nxt;
      end
   end

   assign bus.nib       = nib_q;
   assign bus.nib_valid = valid_q;
   assign bus.busy      = busy_q;
   assign bus.frame_err = err_q;

endmodule

// File: tb/tb_nibble_deserializer.sv
// Bench for nibble_deserializer: both bit orders side by side against a frame-level model.
module tb_nibble_deserializer;

`ifdef NIBBLE_DESER_PARITY_EN
   localparam int NBITS = 5;
`else
   localparam int NBITS = 4;
`endif

   logic clk = 1'b0;
   logic rst_n = 1'b1;
   logic start = 1'b0, sin = 1'b0, sin_valid = 1'b0, out_ready = 1'b0;

   always #5 clk = ~clk;

   nibble_deserializer_if bus_m ();
   nibble_deserializer_if bus_l ();

   assign bus_m.start = start;  assign bus_m.sin = sin;
   assign bus_m.sin_valid = sin_valid;  assign bus_m.out_ready = out_ready;
   assign bus_l.start = start;  assign bus_l.sin = sin;
   assign bus_l.sin_valid = sin_valid;  assign bus_l.out_ready = out_ready;

   nibble_deserializer #(.MSB_FIRST(1'b1)) dut_m (.clk(clk), .rst_n(rst_n), .bus(bus_m.slave));
   nibble_deserializer #(.MSB_FIRST(1'b0)) dut_l (.clk(clk), .rst_n(rst_n), .bus(bus_l.slave));

   int n_vec = 0;
   int n_err = 0;

   // Frame-level reference: collected bits, whether a frame is open, whether a nibble waits
   bit       q[$];
   bit       active = 1'b0;
   bit       pending = 1'b0;
   bit       exp_err = 1'b0;
   bit [3:0] val_m = '0, val_l = '0;

   task automatic check(input string tag, input logic [3:0] got, input logic [3:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic bit [3:0] pack(input bit msb);
      bit [3:0] v = '0;
      for (int i = 0; i < 4; i++) begin
         if (msb) v[3-i] = q[i];
         else     v[i]   = q[i];
      end
      return v;
   endfunction

   function automatic bit parity_ok();
      int ones = 0;
      foreach (q[i]) ones += int'(q[i]);
`ifdef NIBBLE_DESER_PARITY_EN
      return (ones % 2) == 0;
`else
      return 1'b1;
`endif
   endfunction

   task automatic model_reset();
      q.delete();
      active = 1'b0;  pending = 1'b0;  exp_err = 1'b0;
   endtask

   task automatic model_step();
      exp_err = 1'b0;
      if (pending) begin
         if (out_ready) pending = 1'b0;
      end else if (active) begin
         if (start) begin
            exp_err = 1'b1;
            q.delete();
         end else if (sin_valid) begin
            q.push_back(sin);
            if (q.size() == NBITS) begin
               if (parity_ok()) begin
                  val_m = pack(1'b1);
                  val_l = pack(1'b0);
                  pending = 1'b1;
               end else begin
                  exp_err = 1'b1;
               end
               active = 1'b0;
               q.delete();
            end
         end
      end else if (start) begin
         active = 1'b1;
         q.delete();
      end
   endtask

   task automatic check_all();
      check("m_nib",   bus_m.nib,       pending ? 4'(val_m) : 4'h0);
      check("m_valid", 4'(bus_m.nib_valid), 4'(pending));
      check("m_busy",  4'(bus_m.busy),      4'(active | pending));
      check("m_err",   4'(bus_m.frame_err), 4'(exp_err));
      check("l_nib",   bus_l.nib,       pending ? 4'(val_l) : 4'h0);
      check("l_valid", 4'(bus_l.nib_valid), 4'(pending));
      check("l_busy",  4'(bus_l.busy),      4'(active | pending));
      check("l_err",   4'(bus_l.frame_err), 4'(exp_err));
   endtask

   task automatic cycle();
      @(posedge clk);
      if (rst_n) model_step();
      #1;
      check_all();
   endtask

   task automatic quiet(input int n);
      start = 1'b0;  sin_valid = 1'b0;  out_ready = 1'b0;
      repeat (n) cycle();
   endtask

   task automatic do_start();
      start = 1'b1;  sin_valid = 1'b0;  out_ready = 1'b0;
      cycle();
      start = 1'b0;
   endtask

   task automatic send_bit(input bit b, input int gap);
      start = 1'b0;  out_ready = 1'b0;  sin = b;  sin_valid = 1'b1;
      cycle();
      sin_valid = 1'b0;
      repeat (gap) cycle();
   endtask

   // Data bits in arrival order d[3]..d[0]; appends the parity bit when parity is built in
   task automatic send_frame(input bit [3:0] d, input int gap, input bit good_par);
      for (int i = 3; i >= 0; i--) send_bit(d[i], gap);
`ifdef NIBBLE_DESER_PARITY_EN
      send_bit((^d) ^ ~good_par, gap);
`else
      if (!good_par) quiet(0);
`endif
   endtask

   task automatic release_out();
      start = 1'b0;  sin_valid = 1'b0;  out_ready = 1'b1;
      cycle();
      out_ready = 1'b0;
   endtask

   task automatic async_reset_pulse();
      #2 rst_n = 1'b0;
      #1 model_reset();
      check_all();
      @(negedge clk) rst_n = 1'b1;
   endtask

   initial begin
      // Reset state
      #2 rst_n = 1'b0;
      #1 model_reset();
      check("rst_nib", bus_m.nib, 4'h0);
      check("rst_valid", 4'(bus_m.nib_valid), 4'h0);
      check("rst_busy", 4'(bus_m.busy), 4'h0);
      check("rst_err", 4'(bus_m.frame_err), 4'h0);
      @(negedge clk) rst_n = 1'b1;
      quiet(2);

      // Frame 1,0,1,1 held three cycles, then released
      do_start();
      check("start_busy", 4'(bus_m.busy), 4'h1);
      send_frame(4'b1011, 0, 1'b1);
      check("f1_m_nib", bus_m.nib, 4'b1011);
      check("f1_l_nib", bus_l.nib, 4'b1101);
      for (int i = 0; i < 3; i++) begin
         quiet(1);
         check("hold_nib", bus_m.nib, 4'b1011);
      end
      release_out();
      check("clr_nib", bus_m.nib, 4'h0);
      check("clr_valid", 4'(bus_m.nib_valid), 4'h0);

      // LSB-first with two-cycle gaps between bits
      do_start();
      send_frame(4'b1000, 2, 1'b1);
      check("gap_l_nib", bus_l.nib, 4'b0001);
      release_out();

`ifdef NIBBLE_DESER_PARITY_EN
      // Parity error: pulse, no output, back to idle
      do_start();
      send_frame(4'b1101, 0, 1'b0);
      check("par_err", 4'(bus_m.frame_err), 4'h1);
      check("par_busy", 4'(bus_m.busy), 4'h0);
      quiet(1);
      check("par_err_gone", 4'(bus_m.frame_err), 4'h0);
`endif

      // Abort after two bits, then a fresh frame
      do_start();
      send_bit(1'b1, 0);
      send_bit(1'b0, 0);
      start = 1'b1;  sin = 1'b1;  sin_valid = 1'b1;
      cycle();
      check("abort_err", 4'(bus_m.frame_err), 4'h1);
      start = 1'b0;  sin_valid = 1'b0;
      send_frame(4'b0110, 0, 1'b1);
      check("abort_nib", bus_m.nib, 4'b0110);
      release_out();

      // Asynchronous reset while an F nibble is pending
      do_start();
      send_frame(4'b1111, 0, 1'b1);
      check("pre_rst_nib", bus_m.nib, 4'hF);
      async_reset_pulse();
      check("arst_nib", bus_m.nib, 4'h0);
      check("arst_valid", 4'(bus_m.nib_valid), 4'h0);
      check("arst_busy", 4'(bus_m.busy), 4'h0);
      quiet(1);

      // Inputs toggling during OUT are ignored, then an immediate new frame
      do_start();
      send_frame(4'b1001, 0, 1'b1);
      for (int i = 0; i < 5; i++) begin
         start = 1'($urandom);  sin = 1'($urandom);  sin_valid = 1'($urandom);
         out_ready = 1'b0;
         cycle();
         check("out_hold", bus_m.nib, 4'b1001);
      end
      release_out();
      do_start();
      send_frame(4'b0101, 0, 1'b1);
      check("b2b_nib", bus_m.nib, 4'b0101);
      release_out();

      // Random traffic
      for (int i = 0; i < 3000; i++) begin
         start     = ($urandom_range(0, 11) == 0);
         sin       = 1'($urandom);
         sin_valid = 1'($urandom);
         out_ready = ($urandom_range(0, 2) == 0);
         cycle();
         if ($urandom_range(0, 399) == 0) async_reset_pulse();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
